// File: rtl/ca_step_engine.sv
// ca_step_engine: one-dimensional cellular automaton stepper.
// Holds an N-cell pattern and applies a rule lookup table for a requested
// number of generations. Neighbourhoods are either {right, self} (NBR=2) or
// {right, self, left} (NBR=3). The edge cells either wrap around as a ring or
// see zeros beyond the ends. A three-state controller sequences load, run,
// pause and completion.
module ca_step_engine #(
   parameter int N   = 8,
   parameter int NBR = 2,
   parameter int GW  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [N-1:0]          seed,
   input  logic [(1<<NBR)-1:0]   rule,
   input  logic                  wrap,
   input  logic                  start,
   input  logic [GW-1:0]         steps,
   input  logic                  hold,
   output logic [N-1:0]          state,
   output logic                  busy,
   output logic                  done,
   output logic [GW-1:0]         gen
);

   localparam int RW = 1 << NBR;

   // Reject unsupported parameter values at elaboration time.
   if (NBR != 2 && NBR != 3) begin : g_bad_nbr
      $error("ca_step_engine: NBR must be 2 or 3");
   end
   if (N < 3) begin : g_bad_n
      $error("ca_step_engine: N must be at least 3");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t          fsm_q, fsm_d;
   logic [N-1:0]  cells_q, cells_d;
   logic [GW-1:0] gen_q, gen_d;
   logic [GW-1:0] rem_q, rem_d;
   logic [RW-1:0] rule_q, rule_d;
   logic          wrap_q, wrap_d;

   // Next generation for every cell, computed in parallel from the
   // registered pattern and the rule/boundary mode latched at start.
   logic [N-1:0]  next_cells;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cell
         localparam int IP = (gi + 1) % N;
         logic right_b;

         // The last cell only sees cell 0 on its right when the ring is closed.
         if (gi == N - 1) begin : g_right_edge
            assign right_b = wrap_q & cells_q[IP];
         end else begin : g_right_inner
            assign right_b = cells_q[IP];
         end

         if (NBR == 3) begin : g_nbr3
            localparam int IM = (gi + N - 1) % N;
            logic       left_b;
            logic [2:0] code;
            // Cell 0 only sees cell N-1 on its left when the ring is closed.
            if (gi == 0) begin : g_left_edge
               assign left_b = wrap_q & cells_q[IM];
            end else begin : g_left_inner
               assign left_b = cells_q[IM];
            end
            assign code           = {right_b, cells_q[gi], left_b};
            assign next_cells[gi] = rule_q[code];
         end else begin : g_nbr2
            logic [1:0] code;
            assign code           = {right_b, cells_q[gi]};
            assign next_cells[gi] = rule_q[code];
         end
      end
   endgenerate

   // Controller: load/start in IDLE, one generation per unheld cycle in RUN,
   // a single DONE cycle before returning to IDLE.
   always_comb begin
      fsm_d   = fsm_q;
      cells_d = cells_q;
      gen_d   = gen_q;
      rem_d   = rem_q;
      rule_d  = rule_q;
      wrap_d  = wrap_q;
      case (fsm_q)
         IDLE: begin
            if (load) begin
               // load wins over a simultaneous start
               cells_d = seed;
               gen_d   = '0;
            end else if (start) begin
               rule_d = rule;
               wrap_d = wrap;
               rem_d  = steps;
               fsm_d  = (steps == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (!hold) begin
               cells_d = next_cells;
               gen_d   = gen_q + 1'b1;
               rem_d   = rem_q - 1'b1;
               if (rem_q == GW'(1)) begin
                  fsm_d = DONE;
               end
            end
         end
         DONE: begin
            if (load) begin
               cells_d = seed;
               gen_d   = '0;
            end
            fsm_d = IDLE;
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   // State register with asynchronous clear; a reset mid-run aborts silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= IDLE;
         cells_q <= '0;
         gen_q   <= '0;
         rem_q   <= '0;
         rule_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         cells_q <= cells_d;
         gen_q   <= gen_d;
         rem_q   <= rem_d;
         rule_q  <= rule_d;
         wrap_q  <= wrap_d;
      end
   end

   assign state = cells_q;
   assign gen   = gen_q;
   assign busy  = (fsm_q == RUN);
   assign done  = (fsm_q == DONE);

endmodule

// File: tb/tb_ca_step_engine.sv
// Testbench for ca_step_engine: two instances (NBR=2 and NBR=3) share all
// stimulus; expected results are queued when a run is launched and compared
// when its done pulse appears.
module tb_ca_step_engine;

   localparam int GW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load = 1'b0;
   logic [7:0]    seed = '0;
   logic [3:0]    rule2 = '0;
   logic [7:0]    rule3 = '0;
   logic          wrap = 1'b0;
   logic          start = 1'b0;
   logic [GW-1:0] steps = '0;
   logic          hold = 1'b0;
   logic [7:0]    state2, state3;
   logic          busy2, busy3, done2, done3;
   logic [GW-1:0] gen2, gen3;

   ca_step_engine #(.N(8), .NBR(2), .GW(GW)) dut2 (
      .clk(clk), .reset(reset), .load(load), .seed(seed), .rule(rule2),
      .wrap(wrap), .start(start), .steps(steps), .hold(hold),
      .state(state2), .busy(busy2), .done(done2), .gen(gen2));

   ca_step_engine #(.N(8), .NBR(3), .GW(GW)) dut3 (
      .clk(clk), .reset(reset), .load(load), .seed(seed), .rule(rule3),
      .wrap(wrap), .start(start), .steps(steps), .hold(hold),
      .state(state3), .busy(busy3), .done(done3), .gen(gen3));

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic [7:0] seed;
      logic [3:0] r2;
      logic [7:0] r3;
      logic       wrap;
      int         steps;
      logic [7:0] e2;
      logic [7:0] e3;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] st2;
      logic [7:0] st3;
      logic [7:0] gen;
      int         busy;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Independent reference: walk every cell with explicit edge handling.
   function automatic logic [7:0] model(input logic [7:0] s, input logic [7:0] rl,
                                        input bit wr, input int nbr, input int n_steps);
      logic [7:0] c, n;
      bit bl, bc, br;
      int code;
      c = s;
      n = '0;
      for (int k = 0; k < n_steps; k++) begin
         for (int i = 0; i < 8; i++) begin
            bc = c[i];
            if (i == 7) br = wr ? c[0] : 1'b0; else br = c[i+1];
            if (i == 0) bl = wr ? c[7] : 1'b0; else bl = c[i-1];
            if (nbr == 2) code = int'(br) * 2 + int'(bc);
            else          code = int'(br) * 4 + int'(bc) * 2 + int'(bl);
            n[i] = rl[code];
         end
         c = n;
      end
      return c;
   endfunction

   task automatic load_seed(input logic [7:0] s);
      seed = s;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Launch a run and follow it to its done pulse (bounded), optionally
   // pausing and optionally disturbing every control input while busy.
   task automatic do_run(input int steps_i, input int hold_at, input int hold_len,
                         input bit disturb, input bit start_in_done,
                         output int busy_cycles, output bit got_done, output bit clean_after);
      busy_cycles = 0;
      got_done = 1'b0;
      steps = GW'(steps_i);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         if (done2 || done3) begin
            got_done = done2 && done3 && !busy2 && !busy3;
            break;
         end
         if (!(busy2 && busy3)) break;
         busy_cycles++;
         hold = (busy_cycles > hold_at) && (busy_cycles <= hold_at + hold_len);
         if (disturb) begin
            load  = 1'b1;
            start = 1'b1;
            seed  = 8'($urandom);
            rule2 = 4'($urandom);
            rule3 = 8'($urandom);
            wrap  = ~wrap;
            steps = GW'($urandom);
         end
         @(negedge clk);
      end
      hold  = 1'b0;
      load  = 1'b0;
      start = start_in_done;
      @(negedge clk);
      start = 1'b0;
      clean_after = !done2 && !done3 && !busy2 && !busy3;
   endtask

   task automatic finish_run(input int steps_i, input int hold_at, input int hold_len,
                             input bit disturb, input bit start_in_done);
      int bc;
      bit gd, ca;
      exp_t e;
      do_run(steps_i, hold_at, hold_len, disturb, start_in_done, bc, gd, ca);
      e = sb.pop_front();
      check({e.name, " done"}, 32'(gd), 32'd1);
      check({e.name, " busy_cycles"}, bc, e.busy);
      check({e.name, " state2"}, 32'(state2), 32'(e.st2));
      check({e.name, " state3"}, 32'(state3), 32'(e.st3));
      check({e.name, " gen2"}, 32'(gen2), 32'(e.gen));
      check({e.name, " gen3"}, 32'(gen3), 32'(e.gen));
      check({e.name, " idle_after_done"}, 32'(ca), 32'd1);
      $display("run %s: steps=%0d busy=%0d state2=%02h state3=%02h gen=%0d",
               e.name, steps_i, bc, state2, state3, gen2);
   endtask

   task automatic apply_vec(input string nm, input vec_t v);
      exp_t e;
      load_seed(v.seed);
      check({nm, " load2"}, 32'(state2), 32'(v.seed));
      check({nm, " load3"}, 32'(state3), 32'(v.seed));
      rule2 = v.r2;
      rule3 = v.r3;
      wrap  = v.wrap;
      e.name = nm; e.st2 = v.e2; e.st3 = v.e3; e.gen = 8'(v.steps); e.busy = v.steps;
      sb.push_back(e);
      finish_run(v.steps, 0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      exp_t e;
      logic [7:0] s0;

      // Spec vectors with hand-derived results, then model-derived ones.
      vecs[0] = '{8'h01, 4'b0110, 8'h5A, 1'b1, 1, 8'h81, 8'h82};
      vecs[1] = '{8'h01, 4'b0110, 8'h5A, 1'b0, 1, 8'h01, 8'h02};
      vecs[2] = '{8'h10, 4'b0110, 8'h5A, 1'b1, 1, 8'h18, 8'h28};
      vecs[3] = '{8'h10, 4'b0110, 8'h5A, 1'b1, 2, 8'h14, 8'h44};
      vecs[4] = '{8'h5A, 4'b1001, 8'hC3, 1'b1, 0, 8'h5A, 8'h5A};
      for (int i = 5; i < 8; i++) begin
         vecs[i].seed  = 8'($urandom);
         vecs[i].r2    = 4'($urandom);
         vecs[i].r3    = 8'($urandom);
         vecs[i].wrap  = 1'($urandom);
         vecs[i].steps = int'($urandom_range(2, 12));
         vecs[i].e2 = model(vecs[i].seed, {4'b0, vecs[i].r2}, vecs[i].wrap, 2, vecs[i].steps);
         vecs[i].e3 = model(vecs[i].seed, vecs[i].r3, vecs[i].wrap, 3, vecs[i].steps);
      end

      // Reset values.
      #12;
      check("reset state2", 32'(state2), 32'd0);
      check("reset gen3", 32'(gen3), 32'd0);
      check("reset busy", 32'({busy2, busy3}), 32'd0);
      check("reset done", 32'({done2, done3}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

      // Hold for two cycles mid-run while every other input is disturbed;
      // start is also held during the DONE cycle and must be ignored.
      load_seed(8'h10);
      rule2 = 4'b0110; rule3 = 8'h5A; wrap = 1'b1;
      e.name = "hold"; e.busy = 5; e.gen = 8'd3;
      e.st2 = model(8'h10, 8'h06, 1'b1, 2, 3);
      e.st3 = model(8'h10, 8'h5A, 1'b1, 3, 3);
      sb.push_back(e);
      finish_run(3, 1, 2, 1'b1, 1'b1);

      // Load and start together: load executes, controller stays idle.
      seed = 8'hC3; load = 1'b1; start = 1'b1; steps = 8'd5;
      @(negedge clk);
      load = 1'b0; start = 1'b0;
      check("load+start state2", 32'(state2), 32'hC3);
      check("load+start gen2", 32'(gen2), 32'd0);
      check("load+start busy", 32'({busy2, busy3, done2, done3}), 32'd0);
      @(negedge clk);
      check("load+start idle", 32'({busy2, busy3, done2, done3}), 32'd0);
      $display("seq load+start: state2=%02h busy=%0b", state2, busy2);

      // Generation counter wraps past 2^GW-1 without disturbing the run.
      s0 = 8'h37;
      load_seed(s0);
      rule2 = 4'b0110; rule3 = 8'h1E; wrap = 1'b1;
      e.name = "gen200"; e.busy = 200; e.gen = 8'd200;
      e.st2 = model(s0, 8'h06, 1'b1, 2, 200);
      e.st3 = model(s0, 8'h1E, 1'b1, 3, 200);
      sb.push_back(e);
      finish_run(200, 0, 0, 1'b0, 1'b0);
      e.name = "genwrap"; e.busy = 100; e.gen = 8'd44;
      e.st2 = model(s0, 8'h06, 1'b1, 2, 300);
      e.st3 = model(s0, 8'h1E, 1'b1, 3, 300);
      sb.push_back(e);
      finish_run(100, 0, 0, 1'b0, 1'b0);

      // Asynchronous reset mid-run aborts immediately with no done pulse.
      load_seed(8'hA5);
      rule2 = 4'b0110; rule3 = 8'h5A; wrap = 1'b1;
      steps = 8'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-reset busy", 32'({busy2, busy3}), 32'b11);
      #2 reset = 1'b1;
      #1;
      check("midrun reset busy", 32'({busy2, busy3}), 32'd0);
      check("midrun reset state", 32'({state2, state3}), 32'd0);
      check("midrun reset gen", 32'({gen2, gen3}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("no done after reset", 32'({done2, done3, busy2, busy3}), 32'd0);
      end
      $display("seq reset: state2=%02h gen2=%0d busy=%0b", state2, gen2, busy2);
      apply_vec("post_reset", vecs[3]);

      if (sb.size() != 0) begin
         total_cnt++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
